// File: rtl/int_arbiter.sv
// int_arbiter: interrupt arbiter in front of CP0 HWInt[7:2] with pending/mask/mode registers.
// Define INT_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
`default_nettype none

module int_arbiter #(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [2:0]       addr,
    input  logic             we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic             taken,
    output logic [5:0]       hwint,
    output logic [2:0]       cur_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t           r_state;
    logic [N_SRC-1:0] r_s1;
    logic [N_SRC-1:0] r_s2;
    logic [N_SRC-1:0] r_s3;
    logic [N_SRC-1:0] r_pend;
    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] r_mode;
    logic [5:0]       r_hwint;
    logic [2:0]       r_cur_id;
    logic             r_busy;

    logic [N_SRC-1:0] w_elig;
    logic [N_SRC-1:0] w_edge;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_pend_nxt;
    logic [2:0]       w_win;
    logic [2:0]       w_rr_ptr;
    logic             w_wr_pend;
    logic             w_take;
    logic             w_eoi;
    logic             w_unused;

    assign w_unused  = ^wdata[31:N_SRC];
    assign w_elig    = r_pend & r_mask;
    assign w_edge    = r_s2 & ~r_s3;
    assign w_wr_pend = we && (addr == 3'd0);
    assign w_take    = (r_state == S_ASSERT) && taken;
    assign w_eoi     = (r_state == S_SERVICE) && we && (addr == 3'd4);

    always_comb begin
        w_clr = w_wr_pend ? wdata[N_SRC-1:0] : '0;
        if (w_take) begin
            w_clr[r_cur_id] = 1'b1;
        end
    end

    // Edge sources: a new edge beats any clear; level sources simply follow the synchroniser.
    assign w_pend_nxt = (r_mode & (w_edge | (r_pend & ~w_clr))) | (~r_mode & r_s2);

`ifdef INT_ARB_RR_EN
    logic [2:0] r_rr_ptr;
    logic       w_hit;
    int         w_idx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr_ptr <= 3'd0;
        end else if (w_take) begin
            r_rr_ptr <= (r_cur_id == 3'(N_SRC - 1)) ? 3'd0 : r_cur_id + 3'd1;
        end
    end

    always_comb begin
        w_win = 3'd0;
        w_hit = 1'b0;
        w_idx = 0;
        for (int k = 0; k < N_SRC; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % N_SRC;
            if (!w_hit && w_elig[w_idx]) begin
                w_hit = 1'b1;
                w_win = 3'(w_idx);
            end
        end
    end

    assign w_rr_ptr = r_rr_ptr;
`else
    always_comb begin
        w_win = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win = 3'(i);
            end
        end
    end

    assign w_rr_ptr = 3'd0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s3   <= '0;
            r_pend <= '0;
            r_mask <= '0;
            r_mode <= '0;
        end else begin
            r_s1   <= irq_in;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_pend <= w_pend_nxt;
            if (we && (addr == 3'd1)) begin
                r_mask <= wdata[N_SRC-1:0];
            end
            if (we && (addr == 3'd2)) begin
                r_mode <= wdata[N_SRC-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_hwint  <= 6'd0;
            r_cur_id <= 3'd0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_elig) begin
                        r_cur_id <= w_win;
                        r_hwint  <= 6'd1 << w_win;
                        r_busy   <= 1'b1;
                        r_state  <= S_ASSERT;
                    end
                end
                S_ASSERT: begin
                    // CP0 acceptance wins over a simultaneous withdrawal of the request.
                    if (taken) begin
                        r_hwint <= 6'd0;
                        r_state <= S_SERVICE;
                    end else if (!w_elig[r_cur_id]) begin
                        r_hwint <= 6'd0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_SERVICE: begin
                    if (w_eoi) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_hwint <= 6'd0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            3'd0: rdata = 32'(r_pend);
            3'd1: rdata = 32'(r_mask);
            3'd2: rdata = 32'(r_mode);
            3'd3: begin
                rdata[31]   = r_busy;
                rdata[10:8] = w_rr_ptr;
                rdata[2:0]  = r_cur_id;
            end
            default: rdata = 32'd0;
        endcase
    end

    assign hwint  = r_hwint;
    assign cur_id = r_cur_id;
    assign busy   = r_busy;

endmodule

`default_nettype wire
